// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues one outstanding word read at a time to
// instruction memory and buffers returned words in a small FIFO for decode.
module instr_fetch_unit #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_VALID,
  input  logic [31:0] IMEM_RDATA,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic        INSTR_VALID,
  input  logic        INSTR_READY,
  output logic [31:0] INSTR,
  output logic [31:0] INSTR_PC,
  output logic [11:0] IMM12
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

  state_t            state, state_next;
  logic [29:0]       pc_word;
  logic [31:0]       req_pc;
  logic [CNT_W-1:0]  count;
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic              issue, push, pop;

  logic [31:0] buf_instr [DEPTH];
  logic [31:0] buf_pc    [DEPTH];
  logic [11:0] buf_imm   [DEPTH];

  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^REDIRECT_PC[1:0];

  // Stores place the immediate in two pieces; everything else uses [31:20].
  function automatic logic [11:0] imm_of(input logic [31:0] w);
    if (w[6:0] == 7'b0100011) return {w[31:25], w[11:7]};
    else                      return w[31:20];
  endfunction

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    push       = 1'b0;
    case (state)
      S_REQ: begin
        issue = RST_N && !REDIRECT && (count < FULL);
        if (issue) state_next = S_WAIT;
      end
      S_WAIT: begin
        if (REDIRECT) begin
          state_next = IMEM_VALID ? S_REQ : S_DROP;
        end else if (IMEM_VALID) begin
          push       = 1'b1;
          state_next = S_REQ;
        end
      end
      S_DROP: begin
        if (IMEM_VALID) state_next = S_REQ;
      end
      default: state_next = S_REQ;
    endcase
  end

  assign IMEM_REQ    = issue;
  assign IMEM_ADDR   = {pc_word, 2'b00};
  assign INSTR_VALID = (count != '0);
  assign pop         = INSTR_VALID && INSTR_READY && !REDIRECT;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state   <= S_REQ;
      pc_word <= PC_RESET[31:2];
      req_pc  <= PC_RESET;
      count   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
    end else begin
      state <= state_next;
      if (REDIRECT) begin
        pc_word <= REDIRECT_PC[31:2];
        count   <= '0;
        rd_ptr  <= '0;
        wr_ptr  <= '0;
      end else begin
        if (issue) req_pc <= IMEM_ADDR;
        if (push) begin
          wr_ptr  <= wr_ptr + 1'b1;
          pc_word <= req_pc[31:2] + 30'd1;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (pop && !push) count <= count - 1'b1;
      end
    end
  end

  // NOTE: buffer storage is not reset; the head outputs are masked while empty instead.
  always_ff @(posedge CLK) begin
    if (push) begin
      buf_instr[wr_ptr] <= IMEM_RDATA;
      buf_pc[wr_ptr]    <= req_pc;
      buf_imm[wr_ptr]   <= imm_of(IMEM_RDATA);
    end
  end

  assign INSTR    = INSTR_VALID ? buf_instr[rd_ptr] : '0;
  assign INSTR_PC = INSTR_VALID ? buf_pc[rd_ptr]    : '0;
  assign IMM12    = INSTR_VALID ? buf_imm[rd_ptr]   : '0;

endmodule
